uart_tx_serializer: RTL and testbench
=====================================

Name: uart_tx_serializer

Overview:
- UART transmitter: accepts parallel words through a valid/ready handshake and serializes each onto a single line.
- Frame: start bit, WIDTH_DATABITS data bits LSB-first, optional parity bit, 1 or 2 stop bits.
- Sits on the transmit side, opposite the UART receiver that produces out/valid_out/error/valid_error.
- Its tx line loops back to that receiver in the top-level bench.

Parameters:
- WIDTH_DATABITS, 8 (from item_pack): data word width.
- WIDTH_ERROR, 3 (from item_pack): error code width.
- CLKS_PER_BIT, 16: clk cycles per serial bit; legal range ≥ 2.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- data  input  WIDTH_DATABITS  word to send.
- valid_data  input  1  data valid.
- two_stop  input  1  sampled at accept: 0 = 1 stop bit, 1 = 2 stop bits.
- ready  output  1  block can accept a word this cycle.
- tx  output  1  serial line; idle high.
- busy  output  1  frame in progress.
- done  output  1  one-cycle pulse on the last cycle of the final stop bit.
- error  output  WIDTH_ERROR  error code; valid only when valid_error=1.
- valid_error  output  1  one-cycle error strobe.

Behaviour:
- Reset (rst=1 on a posedge):
  - Outputs go to: tx=1, ready=1, busy=0, done=0, error=0, valid_error=0.
  - State → IDLE; bit counter and baud counter → 0.
  - Reset mid-frame aborts the frame; tx returns high on the next cycle.
- Accept: a word is accepted on a posedge where valid_data=1 and ready=1.
  - data and two_stop are latched into a shift register and config flop.
  - On the next cycle: ready=0, busy=1, tx=0 (start bit).
  - Latency from accept edge to tx falling: 1 cycle.
- ready=1 only in IDLE.
- Overrun: valid_data=1 while ready=0 → valid_error=1 for one cycle with error=3'b001.
  - The word is dropped; the current frame is unaffected.
  - Holding valid_data high produces one strobe per cycle.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1; reloads to 0 on every state/bit change.
  - Each bit is held exactly CLKS_PER_BIT cycles.
- FSM:
  - IDLE → START on accept.
  - START → DATA after CLKS_PER_BIT cycles.
  - DATA: shifts out bit[0] first; bit index 0..WIDTH_DATABITS-1; after the last bit goes to PARITY (if enabled) else STOP.
  - PARITY → STOP after CLKS_PER_BIT cycles.
  - STOP: tx=1 for CLKS_PER_BIT × (1 + two_stop) cycles; done pulses on the final cycle; then → IDLE.
- Back-to-back: ready rises the cycle after done. A word accepted on that cycle starts its start bit with no extra idle time.
- Total frame length: CLKS_PER_BIT × (1 + WIDTH_DATABITS + P + 1 + two_stop), where P = 1 if parity is compiled in, else 0.
- valid_error and done are never asserted during reset.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - Adds input parity_odd (1 bit), latched at accept.
  - PARITY state transmits the even parity of the data (XOR of all bits), inverted when parity_odd=1.
- Undefined:
  - No parity_odd port and no PARITY state; DATA → STOP directly.

Decomposition:
- item_pack holds:
  - WIDTH_DATABITS, WIDTH_ERROR, CLKS_PER_BIT default.
  - State enum uart_tx_state_t {IDLE, START, DATA, PARITY, STOP}.
  - Error codes: ERR_NONE=0, ERR_OVERRUN=1.
  - UART_input_item for the bench driver.
- One sub-module: uart_baud_tick.
  - Parameterized counter with sync clear.
  - Emits a tick on the last cycle of each bit period.

Test Plan (CLKS_PER_BIT=4, WIDTH_DATABITS=8):
- Reset then idle 20 cycles → tx=1, ready=1, busy=0, done/valid_error never 1.
- Send 8'hA5, two_stop=0, parity off:
  - tx sequence per 4-cycle bit: 0,1,0,1,0,0,1,0,1,1.
  - done pulses at cycle 40 after accept; ready=1 at cycle 41.
- Send 8'h3C, two_stop=1 → stop high for 8 cycles; frame length 44 cycles.
- Send 8'hFF then 8'h00 back-to-back (valid_data held) → second start bit begins the cycle after the first done; no gap.
- Assert valid_data with 8'h11 at cycle 10 of a frame → valid_error=1, error=3'b001 for 1 cycle; current frame bits unchanged; 8'h11 never sent.
- With UART_TX_PARITY_EN, send 8'h07 with parity_odd=0 → parity bit=1; with parity_odd=1 → parity bit=0.
- Reset asserted at cycle 15 of a frame → tx=1 next cycle, ready=1, busy=0; a subsequent 8'h5A frame is correct.

Source files
------------

// File: rtl/item_pack.sv
// Shared definitions for the UART transmit path: widths, default bit period,
// FSM state encoding, error codes and the bench-side input item.
package item_pack;

    localparam int WIDTH_DATABITS = 8;
    localparam int WIDTH_ERROR    = 3;
    localparam int CLKS_PER_BIT   = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_tx_state_t;

    localparam logic [WIDTH_ERROR-1:0] ERR_NONE    = 3'd0;
    localparam logic [WIDTH_ERROR-1:0] ERR_OVERRUN = 3'd1;

    typedef struct packed {
        logic [WIDTH_DATABITS-1:0] data;
        logic                      two_stop;
        logic                      parity_odd;
    } UART_input_item;

endpackage

// File: rtl/uart_tx_serializer_baud_tick.sv
// Bit-period timer for the UART transmitter. Counts 0..CLKS_PER_BIT-1 and
// flags the last cycle of each bit period; clear holds it at zero so a new
// frame always starts on a full bit period.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;

    // Free-running bit counter that wraps at the end of every bit period.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt_q <= '0;
        end else if (cnt_q == LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter: start bit, data LSB-first, optional parity, 1 or 2 stops.
// Optional parity bit is compiled in with UART_TX_PARITY_EN.
//
// state  | meaning
// IDLE   | line high, ready for a word
// START  | driving the start bit (low)
// DATA   | shifting data bits out, LSB first
// PARITY | driving the parity bit (only reachable with parity compiled in)
// STOP   | line high for one or two bit periods, done on the final cycle
module uart_tx_serializer
    import item_pack::*;
#(
    parameter int WIDTH_DATABITS = item_pack::WIDTH_DATABITS,
    parameter int WIDTH_ERROR    = item_pack::WIDTH_ERROR,
    parameter int CLKS_PER_BIT   = item_pack::CLKS_PER_BIT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [WIDTH_DATABITS-1:0] data,
    input  logic                      valid_data,
    input  logic                      two_stop,
`ifdef UART_TX_PARITY_EN
    input  logic                      parity_odd,
`endif
    output logic                      ready,
    output logic                      tx,
    output logic                      busy,
    output logic                      done,
    output logic [WIDTH_ERROR-1:0]    error,
    output logic                      valid_error
);

    localparam logic [2:0] S_IDLE   = 3'(IDLE);
    localparam logic [2:0] S_START  = 3'(START);
    localparam logic [2:0] S_DATA   = 3'(DATA);
    localparam logic [2:0] S_PARITY = 3'(PARITY);
    localparam logic [2:0] S_STOP   = 3'(STOP);

    localparam int BW = (WIDTH_DATABITS > 1) ? $clog2(WIDTH_DATABITS) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH_DATABITS - 1);

    logic [2:0]                state_q, state_d;
    logic [WIDTH_DATABITS-1:0] shift_q, shift_d;
    logic [BW-1:0]             bit_q, bit_d;
    logic                      two_stop_q, two_stop_d;
    logic                      stop2_q, stop2_d;
    logic                      par_q, par_d;
    logic                      tx_q, tx_d;
    logic                      done_c;
    logic                      tick;
    logic                      overrun;
    logic [WIDTH_ERROR-1:0]    error_q;
    logic                      valid_error_q;

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .rst  (rst),
        .clear(state_q == S_IDLE),
        .tick (tick)
    );

    // Next-state, shift and line-level decode.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_d      = bit_q;
        two_stop_d = two_stop_q;
        stop2_d    = stop2_q;
        par_d      = par_q;
        done_c     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (valid_data) begin
                    state_d    = S_START;
                    shift_d    = data;
                    bit_d      = '0;
                    two_stop_d = two_stop;
                    stop2_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
                    par_d      = (^data) ^ parity_odd;
`else
                    par_d      = ^data;
`endif
                end
            end
            S_START: begin
                if (tick) state_d = S_DATA;
            end
            S_DATA: begin
                if (tick) begin
                    if (bit_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = shift_q >> 1;
                    end
                end
            end
            S_PARITY: begin
                if (tick) state_d = S_STOP;
            end
            S_STOP: begin
                if (tick) begin
                    if (stop2_q || !two_stop_q) begin
                        state_d = S_IDLE;
                        done_c  = 1'b1;
                    end else begin
                        stop2_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = par_d;
            default:  tx_d = 1'b1;
        endcase
    end

    assign overrun = valid_data && (state_q != S_IDLE);

    // Frame state, datapath and registered line output.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            shift_q    <= '0;
            bit_q      <= '0;
            two_stop_q <= 1'b0;
            stop2_q    <= 1'b0;
            par_q      <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_q      <= bit_d;
            two_stop_q <= two_stop_d;
            stop2_q    <= stop2_d;
            par_q      <= par_d;
            tx_q       <= tx_d;
        end
    end

    // Overrun strobe: one per cycle that a word is offered while busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_error_q <= 1'b0;
            error_q       <= WIDTH_ERROR'(ERR_NONE);
        end else begin
            valid_error_q <= overrun;
            error_q       <= overrun ? WIDTH_ERROR'(ERR_OVERRUN) : WIDTH_ERROR'(ERR_NONE);
        end
    end

    assign ready       = (state_q == S_IDLE);
    assign busy        = !ready;
    assign tx          = tx_q;
    assign done        = done_c && !rst;
    assign error       = error_q;
    assign valid_error = valid_error_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer with CLKS_PER_BIT=4. Frame patterns
// come from a vector table; back-to-back, overrun and mid-frame reset are
// hand-written sequences.
module tb_uart_tx_serializer;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    typedef struct {
        logic [7:0]  data;
        logic        two_stop;
        logic        parity_odd;
        logic [10:0] exp_bits;   // transmitted order, first bit at [nbits-1], parity excluded
        int          nbits;
        logic        exp_par;
    } vec_t;

    logic       clk;
    logic       rst;
    logic [7:0] data;
    logic       valid_data;
    logic       two_stop;
`ifdef UART_TX_PARITY_EN
    logic       parity_odd;
`endif
    logic       ready;
    logic       tx;
    logic       busy;
    logic       done;
    logic [2:0] error;
    logic       valid_error;

    int checks = 0;
    int errors = 0;

    uart_tx_serializer #(
        .WIDTH_DATABITS(8),
        .WIDTH_ERROR   (3),
        .CLKS_PER_BIT  (CPB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .data       (data),
        .valid_data (valid_data),
        .two_stop   (two_stop),
`ifdef UART_TX_PARITY_EN
        .parity_odd (parity_odd),
`endif
        .ready      (ready),
        .tx         (tx),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .valid_error(valid_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic exp_bit(input vec_t v, input int j);
        int idx;
        if (P == 1 && j == 9) return v.exp_par;
        idx = (P == 1 && j > 9) ? j - 1 : j;
        return v.exp_bits[v.nbits - 1 - idx];
    endfunction

    // Called at the first negedge after the accept edge; returns at the
    // negedge following the frame with the line back at idle.
    task automatic check_frame(input vec_t v, input int inject_at, input bit allow_verr);
        int   total;
        int   s;
        int   bad_done;
        int   bad_verr;
        int   bad;
        logic e;
        total    = v.nbits + P;
        s        = 0;
        bad_done = 0;
        bad_verr = 0;
        for (int j = 0; j < total; j++) begin
            bad = 0;
            e   = exp_bit(v, j);
            for (int c = 0; c < CPB; c++) begin
                if (s != 0) @(negedge clk);
                s++;
                if (tx !== e || busy !== 1'b1 || ready !== 1'b0) bad++;
                if (done !== ((j == total - 1) && (c == CPB - 1))) bad_done++;
                if (inject_at != 0 && s == inject_at + 1) begin
                    chk("overrun_strobe", {28'd0, valid_error, error}, {28'd0, 1'b1, 3'b001});
                    valid_data = 1'b0;
                end else if (!allow_verr && valid_error !== 1'b0) begin
                    bad_verr++;
                end
                if (inject_at != 0 && s == inject_at) begin
                    data       = 8'h11;
                    valid_data = 1'b1;
                end
            end
            chk($sformatf("frame_%0h_bit%0d_bad_cycles", v.data, j), bad, 0);
        end
        chk($sformatf("frame_%0h_done_bad_cycles", v.data), bad_done, 0);
        chk($sformatf("frame_%0h_spurious_verr", v.data), bad_verr, 0);
        @(negedge clk);
        chk($sformatf("frame_%0h_idle_after", v.data), {29'd0, tx, ready, busy}, {29'd0, 3'b110});
    endtask

    task automatic send(input vec_t v, input int inject_at);
        chk("ready_before_send", {31'd0, ready}, 32'd1);
        data       = v.data;
        two_stop   = v.two_stop;
`ifdef UART_TX_PARITY_EN
        parity_odd = v.parity_odd;
`endif
        valid_data = 1'b1;
        @(negedge clk);
        valid_data = 1'b0;
        check_frame(v, inject_at, 1'b0);
    endtask

    initial begin
        vec_t vecs[4];
        vec_t v_ff, v_00, v_5a;
        int   bad;

        vecs[0] = '{data: 8'hA5, two_stop: 1'b0, parity_odd: 1'b0, exp_bits: 11'b0_10100101_1,   nbits: 10, exp_par: 1'b0};
        vecs[1] = '{data: 8'h3C, two_stop: 1'b1, parity_odd: 1'b0, exp_bits: 11'b0_00111100_11,  nbits: 11, exp_par: 1'b0};
        vecs[2] = '{data: 8'h07, two_stop: 1'b0, parity_odd: 1'b0, exp_bits: 11'b0_11100000_1,   nbits: 10, exp_par: 1'b1};
        vecs[3] = '{data: 8'h07, two_stop: 1'b0, parity_odd: 1'b1, exp_bits: 11'b0_11100000_1,   nbits: 10, exp_par: 1'b0};
        v_ff    = '{data: 8'hFF, two_stop: 1'b0, parity_odd: 1'b0, exp_bits: 11'b0_11111111_1,   nbits: 10, exp_par: 1'b0};
        v_00    = '{data: 8'h00, two_stop: 1'b1, parity_odd: 1'b0, exp_bits: 11'b0_00000000_11,  nbits: 11, exp_par: 1'b0};
        v_5a    = '{data: 8'h5A, two_stop: 1'b0, parity_odd: 1'b0, exp_bits: 11'b0_01011010_1,   nbits: 10, exp_par: 1'b0};

        rst        = 1'b1;
        data       = 8'h00;
        valid_data = 1'b0;
        two_stop   = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_odd = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("reset_outputs", {26'd0, tx, ready, busy, done, valid_error, error[0]}, {26'd0, 6'b110000});
        chk("reset_error_code", {29'd0, error}, 32'd0);
        rst = 1'b0;

        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ({tx, ready, busy, done, valid_error} !== 5'b11000) bad++;
        end
        chk("idle_20_cycles_bad", bad, 0);

        for (int i = 0; i < 4; i++) send(vecs[i], 0);

        // Back-to-back with valid_data held high throughout.
        data       = v_ff.data;
        two_stop   = v_ff.two_stop;
        valid_data = 1'b1;
        @(negedge clk);
        data       = v_00.data;
        two_stop   = v_00.two_stop;
        check_frame(v_ff, 0, 1'b1);
        @(negedge clk);
        valid_data = 1'b0;
        check_frame(v_00, 0, 1'b0);

        // Overrun offered at cycle 10 of a frame.
        send(v_5a, 10);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || ready !== 1'b1) bad++;
        end
        chk("dropped_word_never_sent", bad, 0);

        // Reset at cycle 15 of a frame.
        data       = v_5a.data;
        two_stop   = 1'b0;
        valid_data = 1'b1;
        @(negedge clk);
        valid_data = 1'b0;
        chk("midreset_frame_started", {31'd0, tx}, 32'd0);
        repeat (14) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("no_done_during_reset", {30'd0, done, valid_error}, 32'd0);
        @(negedge clk);
        chk("midreset_outputs", {27'd0, tx, ready, busy, done, valid_error}, {27'd0, 5'b11000});
        rst = 1'b0;
        @(negedge clk);
        send(v_5a, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
